// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: operation modes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b11;
  localparam logic [1:0] MODE_RSV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: moves the operand by k positions with the fill
// selected by mode; the reserved mode passes the operand through.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned KW    = 1
) (
  input  logic [WIDTH-1:0] op_i,
  input  logic [KW-1:0]    k_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = op_i;
    case (mode_i)
      MODE_SLL: res_o = op_i << k_i;
      MODE_SRL: res_o = op_i >> k_i;
      MODE_SRA: res_o = $unsigned($signed(op_i) >>> k_i);
      default:  res_o = op_i;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative SLL/SRL/SRA unit: shifts up to STEP positions per clock and
// signals completion with a registered busy/done handshake.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] shift,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [1:0]           mode_q, mode_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [KW-1:0]        k;
  logic [WIDTH-1:0]     step_res;
  logic                 unused_shift_hi;

  // Amounts at or above WIDTH wrap by truncation; the upper bits are dropped.
  assign unused_shift_hi = ^shift[WIDTH-1:SHAMT_W];

  always_comb begin
    if (32'(rem_q) >= 32'(STEP)) k = KW'(STEP);
    else                         k = KW'(rem_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .op_i   (work_q),
    .k_i    (k),
    .mode_i (mode_q),
    .res_o  (step_res)
  );

  // result/done are loaded on the edge leaving DONE, so the done pulse (with
  // busy still high) lands in the cycle after DONE while the FSM is in IDLE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          work_d  = X;
          mode_d  = mode;
          rem_d   = (mode == MODE_RSV) ? '0 : shift[SHAMT_W-1:0];
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          work_d = step_res;
          rem_d  = rem_q - SHAMT_W'(k);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        result_d = work_q;
        busy_d   = 1'b1;
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      mode_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances, vector table plus
// handshake and asynchronous-reset sequences, checked through a scoreboard.
module tb_seq_shifter;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic [31:0] x;
    logic [31:0] sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          n;
  } sb_t;

  logic        clk, rst;
  logic        start1, start4, busy1, busy4, done1, done4;
  logic [1:0]  mode1, mode4;
  logic [31:0] x1, x4, sh1, sh4, res1, res4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dcnt1 = 0;
  logic dprev1 = 1'b0, dprev4 = 1'b0;
  sb_t q1[$];
  sb_t q4[$];
  vec_t vt[14];

  seq_shifter #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .X(x1), .shift(sh1),
    .result(res1), .busy(busy1), .done(done1));

  seq_shifter #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .X(x4), .shift(sh4),
    .result(res4), .busy(busy4), .done(done4));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int calc_n(input int sel, input logic [1:0] m, input logic [31:0] sh);
    int step;
    step = (sel == 0) ? 1 : 4;
    if (m == 2'b10) return 0;
    return (int'(sh[4:0]) + step - 1) / step;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic mon(input int sel, input logic d, input logic [31:0] r);
    sb_t e;
    if (!d) return;
    chk($sformatf("done_width%0d", sel), {31'b0, (sel == 0) ? dprev1 : dprev4}, 32'd0);
    checks++;
    if ((sel == 0 && q1.size() == 0) || (sel == 1 && q4.size() == 0)) begin
      failures++;
      $display("FAIL spurious_done%0d: got done with no pending request, expected none", sel);
      return;
    end
    e = (sel == 0) ? q1.pop_front() : q4.pop_front();
    chk($sformatf("result%0d", sel), r, e.exp);
    chk($sformatf("latency%0d", sel), cyc - e.acc, e.n + 2);
  endtask

  always @(negedge clk) begin
    mon(0, done1, res1);
    mon(1, done4, res4);
    if (done1) dcnt1++;
    dprev1 = done1;
    dprev4 = done4;
  end

  task automatic set_in(input int sel, input logic s, input logic [1:0] m,
                        input logic [31:0] x, input logic [31:0] sh);
    if (sel == 0) begin start1 = s; mode1 = m; x1 = x; sh1 = sh; end
    else          begin start4 = s; mode4 = m; x4 = x; sh4 = sh; end
  endtask

  task automatic push(input int sel, input logic [31:0] exp, input int acc, input int n);
    sb_t e;
    e.exp = exp; e.acc = acc; e.n = n;
    if (sel == 0) q1.push_back(e); else q4.push_back(e);
  endtask

  task automatic wait_idle(input int sel);
    int sz;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      sz = (sel == 0) ? q1.size() : q4.size();
      if (sz == 0) return;
    end
    checks++; failures++;
    $display("FAIL timeout%0d: done not seen within 200 cycles, expected done", sel);
    if (sel == 0) q1.delete(); else q4.delete();
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    set_in(v.sel, 1'b1, v.mode, v.x, v.sh);
    @(posedge clk); #1;
    push(v.sel, v.exp, cyc, calc_n(v.sel, v.mode, v.sh));
    set_in(v.sel, 1'b0, 2'b00, $urandom, $urandom);
    wait_idle(v.sel);
  endtask

  initial begin
    int c0;
    vt[0]  = '{0, 2'b01, 32'h00000001, 32'd2,        32'h00000000};
    vt[1]  = '{0, 2'b01, 32'h80000000, 32'd31,       32'h00000001};
    vt[2]  = '{0, 2'b11, 32'hA5A5A5A5, 32'd16,       32'hFFFFA5A5};
    vt[3]  = '{0, 2'b01, 32'hA5A5A5A5, 32'd16,       32'h0000A5A5};
    vt[4]  = '{0, 2'b00, 32'h55555555, 32'd1,        32'hAAAAAAAA};
    vt[5]  = '{0, 2'b00, 32'h12345678, 32'd8,        32'h34567800};
    vt[6]  = '{0, 2'b01, 32'h00000004, 32'h00000021, 32'h00000002};
    vt[7]  = '{1, 2'b11, 32'h80000000, 32'd31,       32'hFFFFFFFF};
    vt[8]  = '{1, 2'b00, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF};
    vt[9]  = '{1, 2'b10, 32'h12345678, 32'd5,        32'h12345678};
    vt[10] = '{1, 2'b01, 32'h00000004, 32'h00000021, 32'h00000002};
    vt[11] = '{1, 2'b11, 32'h7FFFFFFF, 32'd4,        32'h07FFFFFF};
    vt[12] = '{1, 2'b01, 32'hF0000000, 32'hFFFFFFE6, 32'h03C00000};
    vt[13] = '{1, 2'b11, 32'h80000000, 32'd3,        32'hF0000000};

    rst = 1'b1;
    set_in(0, 1'b0, 2'b00, '0, '0);
    set_in(1, 1'b0, 2'b00, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_result1", res1, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_done1", {31'b0, done1}, 32'h0);
    chk("rst_result4", res4, 32'h0);
    chk("rst_busy4", {31'b0, busy4}, 32'h0);
    rst = 1'b0;

    foreach (vt[i]) run(vt[i]);

    // start held high: accepted every N+3 = 6 cycles
    @(negedge clk);
    set_in(0, 1'b1, 2'b00, 32'h00000001, 32'd3);
    dcnt1 = 0;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 5; i++) push(0, 32'h00000008, c0 + 6 * i, 3);
    repeat (24) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    wait_idle(0);
    repeat (8) @(negedge clk);
    chk("held_start_dones", dcnt1, 32'd5);

    // start pulses during SHIFT with other operands are ignored
    vt[0] = '{0, 2'b11, 32'hA5A5A5A5, 32'd16, 32'hFFFFA5A5};
    @(negedge clk);
    set_in(0, 1'b1, vt[0].mode, vt[0].x, vt[0].sh);
    @(posedge clk); #1;
    push(0, vt[0].exp, cyc, 16);
    set_in(0, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd3);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start1 = 1'b1; x1 = $urandom;
      @(negedge clk); start1 = 1'b0;
    end
    chk("busy_mid_shift", {31'b0, busy1}, 32'h1);
    wait_idle(0);
    repeat (10) @(negedge clk);

    // asynchronous reset in the middle of a 20-position shift
    @(negedge clk);
    set_in(0, 1'b1, 2'b01, 32'hFFFFFFFF, 32'd20);
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("busy_before_rst", {31'b0, busy1}, 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_result", res1, 32'h0);
    chk("arst_busy", {31'b0, busy1}, 32'h0);
    chk("arst_done", {31'b0, done1}, 32'h0);
    chk("arst_result4", res4, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run('{0, 2'b11, 32'h80000000, 32'd20, 32'hFFFFF800});
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
